pll_dyn_reconfig: RTL and testbench

- Supervisor/reconfiguration controller for a Gowin GW5A PLL instantiated with dynamic divider, charge-pump and loop-filter selects enabled.
- Holds a parametrised table of NUM_MODES video clock configurations and drives all dynamic select buses for the selected mode.
- Sequences PLL reset, waits for lock with timeout and retry, and qualifies lock stability before asserting clocks_ok.
- Sits beside the HDMI PLL wrapper in the top level; lets the framebuffer switch video timing at run time without resynthesis.

---
 rtl/pll_dyn_reconfig.sv | 209 ++++++++++++++++++++
 tb/tb_pll_dyn_reconfig.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_dyn_reconfig.sv
// Reconfiguration supervisor for a GW5A PLL with dynamic divider/charge-pump/filter selects.
// Applies a table-driven mode, sequences PLL reset, waits for lock with retry, qualifies stability.
module pll_dyn_reconfig #(
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned MODE_W = 2,
  parameter logic [NUM_MODES*6-1:0] IDSEL_TAB  = {NUM_MODES{6'd1}},
  parameter logic [NUM_MODES*6-1:0] FBDSEL_TAB = {NUM_MODES{6'd10}},
  parameter logic [NUM_MODES*7-1:0] MDSEL_TAB  = {NUM_MODES{7'd20}},
  parameter logic [NUM_MODES*7-1:0] ODSEL0_TAB = {NUM_MODES{7'd2}},
  parameter logic [NUM_MODES*7-1:0] ODSEL1_TAB = {NUM_MODES{7'd10}},
  parameter logic [NUM_MODES*6-1:0] ICP_TAB    = {NUM_MODES{6'd8}},
  parameter logic [NUM_MODES*3-1:0] LPFRES_TAB = {NUM_MODES{3'd2}},
  parameter logic [NUM_MODES*2-1:0] LPFCAP_TAB = {NUM_MODES{2'd0}},
  parameter int unsigned RESET_CYCLES = 32,
  parameter int unsigned LOCK_TIMEOUT = 200000,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic              mode_req_ready,
  input  logic              lock_in,
  output logic              pll_reset,
  output logic [5:0]        idsel,
  output logic [5:0]        fbdsel,
  output logic [6:0]        mdsel,
  output logic [6:0]        odsel0,
  output logic [6:0]        odsel1,
  output logic [5:0]        icpsel,
  output logic [2:0]        lpfres,
  output logic [1:0]        lpfcap,
  output logic [MODE_W-1:0] cur_mode,
  output logic              clocks_ok,
  output logic              busy,
  output logic              fail,
  output logic              bad_req,
  output logic [1:0]        retry_cnt
);

  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {APPLY, WAIT_LOCK, STABLE, RUN, FAILED} state_t;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [6:0] mdsel;
    logic [6:0] odsel0;
    logic [6:0] odsel1;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
  } sel_t;

  function automatic sel_t sel_of(input logic [MODE_W-1:0] m);
    sel_t s;
    s.idsel  = IDSEL_TAB[int'(m)*6 +: 6];
    s.fbdsel = FBDSEL_TAB[int'(m)*6 +: 6];
    s.mdsel  = MDSEL_TAB[int'(m)*7 +: 7];
    s.odsel0 = ODSEL0_TAB[int'(m)*7 +: 7];
    s.odsel1 = ODSEL1_TAB[int'(m)*7 +: 7];
    s.icpsel = ICP_TAB[int'(m)*6 +: 6];
    s.lpfres = LPFRES_TAB[int'(m)*3 +: 3];
    s.lpfcap = LPFCAP_TAB[int'(m)*2 +: 2];
    return s;
  endfunction

  state_t             state;
  sel_t               sel_q;
  logic               lock_m, lock_s;
  logic [RST_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [STB_W-1:0]   stb_cnt;

  logic               req_take, req_ok, tmo_done, retry_last, go, give_up;
  logic [MODE_W-1:0]  go_mode;
  logic [1:0]         retry_inc;

  assign idsel  = sel_q.idsel;
  assign fbdsel = sel_q.fbdsel;
  assign mdsel  = sel_q.mdsel;
  assign odsel0 = sel_q.odsel0;
  assign odsel1 = sel_q.odsel1;
  assign icpsel = sel_q.icpsel;
  assign lpfres = sel_q.lpfres;
  assign lpfcap = sel_q.lpfcap;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock_in;
      lock_s <= lock_m;
    end
  end

  // Every path into APPLY (new request, retry, lock loss) funnels through go/go_mode,
  // so selects are only ever reloaded on that edge while pll_reset is raised.
  always_comb begin
    req_take   = mode_req_valid && mode_req_ready;
    req_ok     = 32'(mode_req) < NUM_MODES;
    tmo_done   = tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1);
    retry_last = (32'(retry_cnt) + 32'd1) >= MAX_RETRY;
    retry_inc  = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;
    go         = 1'b0;
    give_up    = 1'b0;
    go_mode    = cur_mode;
    unique case (state)
      WAIT_LOCK: if (!lock_s && tmo_done) begin
        if (retry_last) give_up = 1'b1;
        else            go      = 1'b1;
      end
      RUN: begin
        if (req_take && req_ok) begin
          go      = 1'b1;
          go_mode = mode_req;
        end else if (!lock_s) begin
          go = 1'b1;
        end
      end
      FAILED: if (req_take && req_ok) begin
        go      = 1'b1;
        go_mode = mode_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state          <= APPLY;
      cur_mode       <= '0;
      sel_q          <= sel_of('0);
      pll_reset      <= 1'b1;
      clocks_ok      <= 1'b0;
      busy           <= 1'b1;
      fail           <= 1'b0;
      bad_req        <= 1'b0;
      retry_cnt      <= '0;
      mode_req_ready <= 1'b0;
      rst_cnt        <= '0;
      tmo_cnt        <= '0;
      stb_cnt        <= '0;
    end else begin
      bad_req <= req_take && !req_ok;
      if (go) begin
        state          <= APPLY;
        cur_mode       <= go_mode;
        sel_q          <= sel_of(go_mode);
        pll_reset      <= 1'b1;
        rst_cnt        <= '0;
        busy           <= 1'b1;
        mode_req_ready <= 1'b0;
        clocks_ok      <= 1'b0;
        fail           <= 1'b0;
        if (state == FAILED)         retry_cnt <= '0;
        else if (state == WAIT_LOCK) retry_cnt <= retry_inc;
      end else if (give_up) begin
        state          <= FAILED;
        fail           <= 1'b1;
        busy           <= 1'b0;
        mode_req_ready <= 1'b1;
        pll_reset      <= 1'b1;
        retry_cnt      <= retry_inc;
      end else begin
        unique case (state)
          APPLY: begin
            if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
              pll_reset <= 1'b0;
              tmo_cnt   <= '0;
              state     <= WAIT_LOCK;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              stb_cnt <= '0;
              state   <= STABLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          STABLE: begin
            if (!lock_s) begin
              tmo_cnt <= '0;
              state   <= WAIT_LOCK;
            end else if (stb_cnt == STB_W'(LOCK_STABLE - 1)) begin
              state          <= RUN;
              clocks_ok      <= 1'b1;
              busy           <= 1'b0;
              retry_cnt      <= '0;
              mode_req_ready <= 1'b1;
            end else begin
              stb_cnt <= stb_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_dyn_reconfig.sv
// Self-checking bench for pll_dyn_reconfig: randomized mode switches and lock delays
// against expectations derived from the table contents and the sequencing rules.
module tb_pll_dyn_reconfig;
  localparam int unsigned NM = 3;
  localparam int unsigned MW = 2;
  localparam int unsigned RC = 32;
  localparam int unsigned LT = 1000;
  localparam int unsigned LS = 1024;
  localparam int unsigned MR = 3;

  localparam logic [17:0] ID_T = {6'd5, 6'd3, 6'd1};
  localparam logic [17:0] FB_T = {6'd20, 6'd10, 6'd9};
  localparam logic [20:0] MD_T = {7'd40, 7'd30, 7'd20};
  localparam logic [20:0] O0_T = {7'd4, 7'd2, 7'd1};
  localparam logic [20:0] O1_T = {7'd20, 7'd10, 7'd5};
  localparam logic [17:0] IC_T = {6'd12, 6'd9, 6'd7};
  localparam logic [8:0]  LR_T = {3'd5, 3'd3, 3'd2};
  localparam logic [5:0]  LC_T = {2'd2, 2'd1, 2'd0};

  logic clkin = 1'b0;
  logic reset = 1'b0;
  logic [MW-1:0] mode_req = '0;
  logic mode_req_valid = 1'b0;
  logic lock_in = 1'b0;
  logic mode_req_ready, pll_reset, clocks_ok, busy, fail, bad_req;
  logic [5:0] idsel, fbdsel, icpsel;
  logic [6:0] mdsel, odsel0, odsel1;
  logic [2:0] lpfres;
  logic [1:0] lpfcap, retry_cnt;
  logic [MW-1:0] cur_mode;
  logic [43:0] sel_now;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pll_dyn_reconfig #(
    .NUM_MODES(NM), .MODE_W(MW),
    .IDSEL_TAB(ID_T), .FBDSEL_TAB(FB_T), .MDSEL_TAB(MD_T),
    .ODSEL0_TAB(O0_T), .ODSEL1_TAB(O1_T), .ICP_TAB(IC_T),
    .LPFRES_TAB(LR_T), .LPFCAP_TAB(LC_T),
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)
  ) dut (
    .clkin(clkin), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready), .lock_in(lock_in), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .mdsel(mdsel), .odsel0(odsel0), .odsel1(odsel1),
    .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap), .cur_mode(cur_mode),
    .clocks_ok(clocks_ok), .busy(busy), .fail(fail), .bad_req(bad_req), .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  assign sel_now = {idsel, fbdsel, mdsel, odsel0, odsel1, icpsel, lpfres, lpfcap};

  function automatic logic [43:0] ref_sel(input int m);
    return {6'(ID_T >> (6*m)), 6'(FB_T >> (6*m)), 7'(MD_T >> (7*m)), 7'(O0_T >> (7*m)),
            7'(O1_T >> (7*m)), 6'(IC_T >> (6*m)), 3'(LR_T >> (3*m)), 2'(LC_T >> (2*m))};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic request(input int m);
    mode_req = MW'(m);
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
  endtask

  // Called just after the edge that raised pll_reset; checks pulse length and select stability.
  task automatic expect_reset_pulse(input int m, input string tag);
    int n = 0;
    bit sel_ok = 1'b1;
    if (sel_now !== ref_sel(m)) sel_ok = 1'b0;
    check_val({tag, "_busy"}, {busy, mode_req_ready, clocks_ok}, 3'b100);
    while (pll_reset === 1'b1 && n < int'(RC) + 20) begin
      tick();
      n++;
      if (pll_reset === 1'b1 && sel_now !== ref_sel(m)) sel_ok = 1'b0;
    end
    check_val({tag, "_rst_len"}, 64'(n), 64'(RC));
    check_val({tag, "_sel_hold"}, 64'(sel_ok), 64'd1);
    check_val({tag, "_mode"}, 64'(cur_mode), 64'(m));
  endtask

  // Lock arrives dly cycles after pll_reset release; clocks_ok follows after the
  // 2-stage synchroniser, one detect cycle in WAIT_LOCK, and LS qualified cycles.
  task automatic lock_up(input int m, input int dly, input string tag);
    int n = 0;
    repeat (dly) tick();
    check_val({tag, "_wait"}, {pll_reset, clocks_ok, busy}, 3'b001);
    lock_in = 1'b1;
    while (clocks_ok !== 1'b1 && n < int'(LS) + 50) begin
      tick();
      n++;
    end
    check_val({tag, "_lock_lat"}, 64'(n), 64'(LS + 3));
    check_val({tag, "_run"}, {busy, mode_req_ready, retry_cnt, fail, pll_reset, cur_mode},
              {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, MW'(m)});
    check_val({tag, "_sel"}, sel_now, ref_sel(m));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, n, prev;
    #1 reset = 1'b1;
    #2;
    check_val("rst_state", {pll_reset, clocks_ok, busy, fail, bad_req, retry_cnt, mode_req_ready, cur_mode},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, MW'(0)});
    check_val("rst_sel", sel_now, ref_sel(0));
    repeat (3) @(posedge clkin);
    #1 reset = 1'b0;
    expect_reset_pulse(0, "boot");
    lock_up(0, 100, "boot");

    lock_in = 1'b0;
    request(2);
    check_val("req2_ready", 64'(mode_req_ready), 64'd0);
    expect_reset_pulse(2, "req2");
    lock_up(2, int'($urandom_range(5, 150)), "req2");

    check_val("bad_ready", 64'(mode_req_ready), 64'd1);
    request(3);
    check_val("bad_pulse", {bad_req, clocks_ok, pll_reset, mode_req_ready, cur_mode},
              {1'b1, 1'b1, 1'b0, 1'b1, MW'(2)});
    tick();
    check_val("bad_one", {bad_req, clocks_ok, pll_reset, cur_mode}, {1'b0, 1'b1, 1'b0, MW'(2)});

    prev = 2;
    for (int i = 0; i < 4; i++) begin
      m = int'($urandom_range(0, NM - 1));
      if ($urandom_range(0, 1) == 1) begin
        request(int'($urandom_range(NM, 3)));
        check_val("rnd_bad", {bad_req, clocks_ok, cur_mode}, {1'b1, 1'b1, MW'(prev)});
      end
      lock_in = 1'b0;
      request(m);
      expect_reset_pulse(m, "rnd");
      lock_up(m, int'($urandom_range(5, 150)), "rnd");
      prev = m;
    end

    lock_in = 1'b0;
    request(1);
    expect_reset_pulse(1, "glitch");
    repeat (20) tick();
    lock_in = 1'b1;
    repeat (503) tick();
    check_val("glitch_pre", {clocks_ok, busy}, 2'b01);
    lock_in = 1'b0;
    tick();
    lock_in = 1'b1;
    n = 0;
    while (clocks_ok !== 1'b1 && n < int'(LS) + 50) begin
      tick();
      n++;
    end
    check_val("glitch_restart", 64'(n), 64'(LS + 3));
    check_val("glitch_retry", {retry_cnt, cur_mode}, {2'b00, MW'(1)});

    lock_in = 1'b0;
    n = 0;
    while (clocks_ok === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_val("loss_lat", 64'(n), 64'd3);
    check_val("loss_state", {pll_reset, retry_cnt, cur_mode}, {1'b1, 2'b00, MW'(1)});
    expect_reset_pulse(1, "loss");
    lock_up(1, int'($urandom_range(5, 150)), "loss");

    lock_in = 1'b0;
    tick();
    tick();
    request(0);
    check_val("simul_mode", {cur_mode, retry_cnt, pll_reset}, {MW'(0), 2'b00, 1'b1});
    expect_reset_pulse(0, "simul");
    lock_up(0, int'($urandom_range(5, 150)), "simul");

    lock_in = 1'b0;
    request(2);
    for (int k = 1; k <= int'(MR); k++) begin
      expect_reset_pulse(2, "tmo");
      n = 0;
      while (pll_reset === 1'b0 && n < int'(LT) + 20) begin
        tick();
        n++;
      end
      check_val("tmo_len", 64'(n), 64'(LT));
      check_val("tmo_retry", 64'(retry_cnt), 64'(k));
      if (k < int'(MR)) check_val("tmo_not_fail", {fail, busy}, 2'b01);
    end
    check_val("fail_state", {fail, busy, mode_req_ready, pll_reset, clocks_ok}, 5'b10110);
    repeat (50) tick();
    check_val("fail_hold", {fail, pll_reset}, 2'b11);
    request(1);
    check_val("fail_clear", {fail, retry_cnt}, 3'b000);
    expect_reset_pulse(1, "recover");
    lock_up(1, int'($urandom_range(5, 150)), "recover");

    lock_in = 1'b0;
    request(2);
    expect_reset_pulse(2, "pre_rst");
    repeat (40) tick();
    #3 reset = 1'b1;
    #1;
    check_val("async_rst", {pll_reset, clocks_ok, busy, fail, retry_cnt, mode_req_ready, cur_mode},
              {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, MW'(0)});
    check_val("async_sel", sel_now, ref_sel(0));
    @(posedge clkin);
    #1 reset = 1'b0;
    expect_reset_pulse(0, "reboot");
    lock_up(0, int'($urandom_range(5, 150)), "reboot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
